// File: rtl/stereo_fir_filter.sv
// Stereo FIR filter: one shared MAC serves both channels, with run-time writable shared coefficients.
// Define FIR_SAT_EN to clamp the rounded outputs; without it the outputs wrap to DW bits.
module stereo_fir_filter #(
    parameter int unsigned NTAPS = 32,
    parameter int unsigned DW    = 18,
    parameter int unsigned CW    = 18
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     DIN_RDY,
    input  logic [DW-1:0]            LEFT_IN,
    input  logic [DW-1:0]            RIGHT_IN,
    input  logic                     COEF_WE,
    input  logic [$clog2(NTAPS)-1:0] COEF_ADDR,
    input  logic [CW-1:0]            COEF_DATA,
    output logic [DW-1:0]            LEFT_OUT,
    output logic [DW-1:0]            RIGHT_OUT,
    output logic                     DOUT_VALID,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int unsigned AW   = $clog2(NTAPS);
    localparam int unsigned PW   = DW + CW;
    localparam int unsigned ACCW = DW + CW + AW;

    localparam logic [AW:0]             LastCnt = (AW + 1)'(NTAPS);
    localparam logic signed [ACCW-1:0]  RoundC  = ACCW'(1) << (CW - 2);
`ifdef FIR_SAT_EN
    localparam logic signed [ACCW-1:0]  SatMax  = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0]  SatMin  = ~SatMax;
`endif

    typedef enum logic [2:0] {StIdle, StWrite, StMacL, StMacR, StOut} state_e;

    state_e r_state;
    state_e w_state_next;

    logic signed [CW-1:0]   r_coef   [NTAPS];
    logic signed [DW-1:0]   r_hist_l [NTAPS];
    logic signed [DW-1:0]   r_hist_r [NTAPS];
    logic [DW-1:0]          r_cap_l;
    logic [DW-1:0]          r_cap_r;
    logic [AW-1:0]          r_wptr;
    logic [AW:0]            r_cnt;
    logic signed [PW-1:0]   r_prod;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] r_acc_l;
    logic [DW-1:0]          r_left;
    logic [DW-1:0]          r_right;
    logic                   r_overrun;

    logic [AW-1:0]          w_idx;
    logic                   w_last;
    logic signed [CW-1:0]   w_coef;
    logic signed [DW-1:0]   w_sample;
    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_acc_sum;

    // r_wptr addresses the newest sample during the MAC phases; tap k reads x[n-k].
    assign w_idx     = r_wptr - r_cnt[AW-1:0];
    assign w_last    = (r_cnt == LastCnt);
    assign w_coef    = r_coef[r_cnt[AW-1:0]];
    assign w_sample  = (r_state == StMacL) ? r_hist_l[w_idx] : r_hist_r[w_idx];
    assign w_prod    = {{DW{w_coef[CW-1]}}, w_coef} * {{CW{w_sample[DW-1]}}, w_sample};
    assign w_acc_sum = r_acc + {{AW{r_prod[PW-1]}}, r_prod};

    function automatic logic [DW-1:0] round_sat(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] v;
        v = (acc + RoundC) >>> (CW - 1);
`ifdef FIR_SAT_EN
        if (v > SatMax) begin
            v = SatMax;
        end else if (v < SatMin) begin
            v = SatMin;
        end
`endif
        return v[DW-1:0];
    endfunction

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = (r_state != StIdle);
        DOUT_VALID   = (r_state == StOut);
        case (r_state)
            StIdle:  if (DIN_RDY) w_state_next = StWrite;
            StWrite: w_state_next = StMacL;
            StMacL:  if (w_last) w_state_next = StMacR;
            StMacR:  if (w_last) w_state_next = StOut;
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i]   <= '0;
                r_hist_l[i] <= '0;
                r_hist_r[i] <= '0;
            end
            r_cap_l   <= '0;
            r_cap_r   <= '0;
            r_wptr    <= '0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_acc_l   <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == StIdle && COEF_WE) begin
                r_coef[COEF_ADDR] <= COEF_DATA;
            end
            if (r_state != StIdle && DIN_RDY) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (DIN_RDY) begin
                        r_cap_l <= LEFT_IN;
                        r_cap_r <= RIGHT_IN;
                    end
                end
                StWrite: begin
                    r_hist_l[r_wptr] <= r_cap_l;
                    r_hist_r[r_wptr] <= r_cap_r;
                    r_cnt            <= '0;
                end
                StMacL, StMacR: begin
                    // One-stage product pipeline: the count runs 0..NTAPS, the sum lags by one.
                    r_prod <= w_prod;
                    r_acc  <= (r_cnt == '0) ? '0 : w_acc_sum;
                    r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last && r_state == StMacL) begin
                        r_acc_l <= w_acc_sum;
                    end
                    if (w_last && r_state == StMacR) begin
                        r_left  <= round_sat(r_acc_l);
                        r_right <= round_sat(w_acc_sum);
                    end
                end
                StOut: begin
                    r_wptr <= r_wptr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign LEFT_OUT  = r_left;
    assign RIGHT_OUT = r_right;
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_stereo_fir_filter.sv
// Scoreboard bench for stereo_fir_filter: a behavioural filter model queues expected outputs.
module tb_stereo_fir_filter;

    localparam int N   = 32;
    localparam int CW  = 18;
    localparam int LAT = 2 * N + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_rdy;
    logic [17:0] left_in;
    logic [17:0] right_in;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [17:0] coef_data;
    logic [17:0] left_out;
    logic [17:0] right_out;
    logic        dout_valid;
    logic        busy;
    logic        overrun;

    stereo_fir_filter dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .DIN_RDY    (din_rdy),
        .LEFT_IN    (left_in),
        .RIGHT_IN   (right_in),
        .COEF_WE    (coef_we),
        .COEF_ADDR  (coef_addr),
        .COEF_DATA  (coef_data),
        .LEFT_OUT   (left_out),
        .RIGHT_OUT  (right_out),
        .DOUT_VALID (dout_valid),
        .BUSY       (busy),
        .OVERRUN    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [17:0] l;
        logic [17:0] r;
        int          c;
    } exp_t;
    exp_t exp_q[$];

    longint      m_coef [N];
    longint      m_hl   [N];
    longint      m_hr   [N];
    int          m_wptr;
    int          busy_s;
    int          busy_e;
    logic [17:0] held_l;
    logic [17:0] held_r;
    int          n_dout = 0;
    bit          mon_en = 1'b0;

    function automatic longint sext(input logic [17:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint dot(input bit right);
        longint acc = 0;
        for (int k = 0; k < N; k++) begin
            int idx = (m_wptr - k + N) % N;
            acc += m_coef[k] * (right ? m_hr[idx] : m_hl[idx]);
        end
        return acc;
    endfunction

    function automatic logic [17:0] model_out(input longint acc);
        longint v;
        v = (acc + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
`ifdef FIR_SAT_EN
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
`endif
        return v[17:0];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic until_cyc(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_coef[k] = 0;
            m_hl[k]   = 0;
            m_hr[k]   = 0;
        end
        m_wptr = 0;
        busy_s = 1;
        busy_e = 0;
        held_l = '0;
        held_r = '0;
        exp_q.delete();
    endtask

    // One cycle of stimulus; the model decides acceptance from its own busy window.
    task automatic drive(input bit din, input logic [17:0] l, input logic [17:0] r,
                         input bit we, input int addr, input logic [17:0] data);
        bit   is_busy;
        exp_t e;
        is_busy   = (cyc >= busy_s && cyc <= busy_e);
        din_rdy   = din;
        left_in   = l;
        right_in  = r;
        coef_we   = we;
        coef_addr = addr[4:0];
        coef_data = data;
        if (we && !is_busy) m_coef[addr] = sext(data);
        if (din && !is_busy) begin
            m_hl[m_wptr] = sext(l);
            m_hr[m_wptr] = sext(r);
            e.l = model_out(dot(1'b0));
            e.r = model_out(dot(1'b1));
            e.c = cyc + LAT;
            exp_q.push_back(e);
            m_wptr = (m_wptr + 1) % N;
            busy_s = cyc + 1;
            busy_e = cyc + LAT;
        end
        step(1);
        din_rdy = 1'b0;
        coef_we = 1'b0;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("busy", 32'(busy), 32'(cyc >= busy_s && cyc <= busy_e));
            if (dout_valid) begin
                n_dout++;
                if (exp_q.size() == 0) begin
                    check_eq("dout_unexpected", 32'(dout_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("latency", cyc, mon_e.c);
                    check_eq("left_out", 32'(left_out), 32'(mon_e.l));
                    check_eq("right_out", 32'(right_out), 32'(mon_e.r));
                    held_l = mon_e.l;
                    held_r = mon_e.r;
                end
            end else begin
                check_eq("left_hold", 32'(left_out), 32'(held_l));
                check_eq("right_hold", 32'(right_out), 32'(held_r));
                if (exp_q.size() > 0 && cyc > exp_q[0].c) begin
                    check_eq("dout_missing", 32'(dout_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int n0;
        din_rdy   = 1'b0;
        left_in   = '0;
        right_in  = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        apply_reset();
        mon_en = 1'b1;

        // Idle after reset
        n0 = n_dout;
        step(1000);
        check_eq("idle_dout", n_dout - n0, 0);
        check_eq("idle_left", 32'(left_out), 0);
        check_eq("idle_right", 32'(right_out), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_ovr", 32'(overrun), 0);

        // Gain 0.5, coefficient written in the same cycle as the strobe
        c0 = cyc;
        drive(1'b1, 18'd1000, -18'sd1000, 1'b1, 0, 18'h10000);
        until_cyc(c0 + 5);
        drive(1'b0, 18'd0, 18'd0, 1'b1, 0, 18'h00000);
        until_cyc(c0 + LAT + 1);
        check_eq("gain_left", 32'(left_out), 32'd500);
        check_eq("gain_right", 32'(right_out), 32'h3FE0C);
        check_eq("gain_ovr", 32'(overrun), 0);
        drive(1'b1, 18'd2000, 18'd0, 1'b0, 0, 18'h0);
        step(LAT + 2);
        check_eq("busy_we_ignored", 32'(left_out), 32'd1000);

        // Step response across the history wrap
        apply_reset();
        for (int k = 0; k < N; k++) drive(1'b0, 18'd0, 18'd0, 1'b1, k, 18'h01000);
        for (int n = 1; n <= 40; n++) begin
            drive(1'b1, 18'd4096, 18'd0, 1'b0, 0, 18'h0);
            step(199);
        end
        check_eq("step_final", 32'(left_out), 32'd4096);

        // Full-scale accumulation
        apply_reset();
        for (int k = 0; k < N; k++) drive(1'b0, 18'd0, 18'd0, 1'b1, k, 18'h1FFFF);
        for (int n = 1; n <= 32; n++) begin
            drive(1'b1, 18'h1FFFF, 18'h20000, 1'b0, 0, 18'h0);
            step(79);
        end
`ifdef FIR_SAT_EN
        check_eq("sat_left", 32'(left_out), 32'h1FFFF);
        check_eq("sat_right", 32'(right_out), 32'h20000);
`else
        check_eq("wrap_left", 32'(left_out), 32'h3FFC0);
        check_eq("wrap_right", 32'(right_out), 32'h00020);
`endif

        // Overrun, strobe in the DOUT_VALID cycle, strobe right after it
        apply_reset();
        drive(1'b0, 18'd0, 18'd0, 1'b1, 0, 18'h10000);
        n0 = n_dout;
        c0 = cyc;
        drive(1'b1, 18'd200, 18'd300, 1'b0, 0, 18'h0);
        until_cyc(c0 + 10);
        drive(1'b1, 18'd999, 18'd999, 1'b0, 0, 18'h0);
        step(2);
        check_eq("ovr_set", 32'(overrun), 1);
        until_cyc(c0 + LAT);
        drive(1'b1, 18'd7, 18'd7, 1'b0, 0, 18'h0);
        check_eq("ovr_one_dout", n_dout - n0, 1);
        check_eq("ovr_left", 32'(left_out), 32'd100);
        check_eq("ovr_right", 32'(right_out), 32'd150);
        drive(1'b1, 18'd400, 18'd0, 1'b0, 0, 18'h0);
        step(LAT + 2);
        check_eq("accept_after_dout", 32'(left_out), 32'd200);
        check_eq("ovr_sticky", 32'(overrun), 1);
        check_eq("ovr_two_dout", n_dout - n0, 2);

        // Reset in the middle of the left MAC
        drive(1'b0, 18'd0, 18'd0, 1'b1, 0, 18'h10000);
        c0 = cyc;
        drive(1'b1, 18'd1000, 18'd1000, 1'b0, 0, 18'h0);
        until_cyc(c0 + 30);
        apply_reset();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovr", 32'(overrun), 0);
        n0 = n_dout;
        step(100);
        check_eq("rst_no_dout", n_dout - n0, 0);
        drive(1'b1, 18'd1000, 18'd1000, 1'b0, 0, 18'h0);
        step(LAT + 2);
        check_eq("rst_coef_zero", 32'(left_out), 0);
        check_eq("rst_dout_after", n_dout - n0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
